missile_position: RTL and testbench



---
 rtl/missile_position_if.sv | 23 ++
 rtl/missile_position.sv | 90 +++++++++
 tb/tb_missile_position.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/missile_position_if.sv
// Bundle between the TIA-style register file and the missile position generator.
// The master drives line timing and register writes; the slave returns strobe and columns.
interface missile_position_if;
    logic       visible;
    logic       enable;
    logic       reset_position;
    logic [3:0] hmotion;
    logic       hmotion_write;
    logic       hmove;
    logic       strobe;
    logic [7:0] position;
    logic [7:0] pixel_x;

    modport master (
        output visible, enable, reset_position, hmotion, hmotion_write, hmove,
        input  strobe, position, pixel_x
    );

    modport slave (
        input  visible, enable, reset_position, hmotion, hmotion_write, hmove,
        output strobe, position, pixel_x
    );
endinterface

// File: rtl/missile_position.sv
// Missile horizontal position generator: scanline column counter, programmed column
// with HMOVE motion, and a one-cycle start strobe for the missile width generator.
module missile_position #(
    parameter int LINE_PIXELS        = 160,
    parameter int BLANK_RESET_COLUMN = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    missile_position_if.slave bus
);

    localparam logic [7:0]        LAST_COL  = 8'(LINE_PIXELS - 1);
    localparam logic [7:0]        BLANK_COL = 8'(BLANK_RESET_COLUMN);
    localparam logic [7:0]        LINE_LEN8 = 8'(LINE_PIXELS);
    localparam logic signed [9:0] LINE_LEN  = 10'(LINE_PIXELS);

    logic [7:0]        r_pixel_x;
    logic [7:0]        r_position;
    logic [3:0]        r_motion;
    logic              r_move_pending;
    logic              r_strobe;

    logic              w_apply;
    logic              w_hit;
    logic signed [9:0] w_diff;
    logic [7:0]        w_moved;

    // A move is only ever applied while blanking, either requested now or left pending.
    assign w_apply = ~bus.visible & (bus.hmove | r_move_pending);
    assign w_hit   = bus.visible & bus.enable & (r_pixel_x == r_position);

    // Result lies in -8..LINE_PIXELS+7, so a single correction brings it back into range.
    always_comb begin
        w_diff = $signed({2'b00, r_position}) - $signed({{6{r_motion[3]}}, r_motion});
        if (w_diff[9]) begin
            w_moved = w_diff[7:0] + LINE_LEN8;
        end else if (w_diff >= LINE_LEN) begin
            w_moved = w_diff[7:0] - LINE_LEN8;
        end else begin
            w_moved = w_diff[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pixel_x <= '0;
        end else if (!bus.visible || r_pixel_x == LAST_COL) begin
            r_pixel_x <= '0;
        end else begin
            r_pixel_x <= r_pixel_x + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= w_hit;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_motion <= '0;
        end else if (bus.hmotion_write) begin
            r_motion <= bus.hmotion;
        end
    end

    // reset_position outranks any move; a visible-time HMOVE just arms the pending flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_position     <= '0;
            r_move_pending <= 1'b0;
        end else if (bus.reset_position) begin
            r_position     <= bus.visible ? r_pixel_x : BLANK_COL;
            r_move_pending <= 1'b0;
        end else if (w_apply) begin
            r_position     <= w_moved;
            r_move_pending <= 1'b0;
        end else if (bus.visible && bus.hmove) begin
            r_move_pending <= 1'b1;
        end
    end

    assign bus.strobe   = r_strobe;
    assign bus.position = r_position;
    assign bus.pixel_x  = r_pixel_x;

endmodule

// File: tb/tb_missile_position.sv
// Self-checking bench for missile_position: directed scenarios plus random lines,
// compared every cycle against a plain-arithmetic reference model.
module tb_missile_position;

    localparam int LP        = 160;
    localparam int BLANK_COL = 3;

    logic clk = 1'b0;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    int   m_pix, m_pos, m_motion, m_pend, m_strobe;
    int   strobe_cnt, strobe_pix;

    always #5 clk = ~clk;

    missile_position_if bus ();

    missile_position #(
        .LINE_PIXELS        (LP),
        .BLANK_RESET_COLUMN (BLANK_COL)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_pix    = 0;
        m_pos    = 0;
        m_motion = 0;
        m_pend   = 0;
        m_strobe = 0;
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, check at negedge.
    task automatic cycle(input logic vis, input logic en, input logic rp, input logic hmv,
                         input logic hw, input logic [3:0] hm);
        int nxt_pix, nxt_pos, nxt_pend, nxt_strobe;
        bus.visible        = vis;
        bus.enable         = en;
        bus.reset_position = rp;
        bus.hmove          = hmv;
        bus.hmotion_write  = hw;
        bus.hmotion        = hm;
        @(posedge clk);
        if (!reset_n) begin
            model_clear();
        end else begin
            nxt_strobe = (vis && en && m_pix == m_pos) ? 1 : 0;
            nxt_pix    = vis ? (m_pix + 1) % LP : 0;
            nxt_pos    = m_pos;
            nxt_pend   = m_pend;
            if (rp) begin
                nxt_pos  = vis ? m_pix : BLANK_COL;
                nxt_pend = 0;
            end else if (!vis && (hmv || m_pend != 0)) begin
                nxt_pos  = ((m_pos - m_motion) % LP + LP) % LP;
                nxt_pend = 0;
            end else if (vis && hmv) begin
                nxt_pend = 1;
            end
            if (hw) m_motion = int'($signed(hm));
            m_pix    = nxt_pix;
            m_pos    = nxt_pos;
            m_pend   = nxt_pend;
            m_strobe = nxt_strobe;
        end
        @(negedge clk);
        check_eq("pixel_x", bus.pixel_x, m_pix);
        check_eq("position", bus.position, m_pos);
        check_eq("strobe", bus.strobe, m_strobe);
        if (bus.strobe === 1'b1) begin
            strobe_cnt++;
            strobe_pix = bus.pixel_x;
        end
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic line(input int len, input logic en, input int rp_at, input int hmv_at);
        strobe_cnt = 0;
        strobe_pix = -1;
        for (int i = 0; i < len; i++)
            cycle(1'b1, en, (m_pix == rp_at), (m_pix == hmv_at), 1'b0, 4'd0);
        $display("[tb] line len=%0d en=%0d strobes=%0d strobe_pix=%0d pos=%0d",
                 len, en, strobe_cnt, strobe_pix, bus.position);
    endtask

    initial begin
        logic vis, en;
        int   bl, vl;

        reset_n            = 1'b0;
        bus.visible        = 1'b0;
        bus.enable         = 1'b0;
        bus.reset_position = 1'b0;
        bus.hmove          = 1'b0;
        bus.hmotion_write  = 1'b0;
        bus.hmotion        = 4'd0;
        model_clear();

        // Reset state, including visible/enable high while reset is held.
        @(negedge clk);
        check_eq("rst_strobe", bus.strobe, 0);
        check_eq("rst_position", bus.position, 0);
        check_eq("rst_pixel_x", bus.pixel_x, 0);
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        reset_n = 1'b1;

        // Position 0: one strobe while pixel_x = 1.
        blank(1);
        line(LP, 1'b1, -1, -1);
        check_eq("p0_strobe_count", strobe_cnt, 1);
        check_eq("p0_strobe_pix", strobe_pix, 1);

        // RESM at column 57, strobe next line at pixel_x 58, none with enable low.
        blank(2);
        line(LP, 1'b1, 57, -1);
        check_eq("resm57_position", bus.position, 57);
        blank(2);
        line(LP, 1'b1, -1, -1);
        check_eq("p57_strobe_count", strobe_cnt, 1);
        check_eq("p57_strobe_pix", strobe_pix, 58);
        blank(2);
        line(LP, 1'b0, -1, -1);
        check_eq("enam_off_strobes", strobe_cnt, 0);

        // Blank RESM, then wraps in both directions.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        check_eq("blank_resm", bus.position, 3);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        check_eq("hmove_wrap_low", bus.position, 158);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1000);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        check_eq("hmove_wrap_high", bus.position, 6);

        // Visible HMOVE is deferred to the first blank clock.
        blank(1);
        line(LP, 1'b1, 100, -1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2);
        line(LP, 1'b1, -1, 20);
        check_eq("deferred_hold", bus.position, 100);
        blank(1);
        check_eq("deferred_apply", bus.position, 98);
        blank(3);
        check_eq("pending_cleared", bus.position, 98);

        // RESM beats a coincident HMOVE.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        check_eq("resm_beats_hmove", bus.position, 3);
        blank(2);
        check_eq("hmove_discarded", bus.position, 3);

        // Motion write coincident with a pending apply uses the old motion.
        line(LP, 1'b1, 10, 50);
        check_eq("pend_before_apply", bus.position, 10);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1101);
        check_eq("apply_old_motion", bus.position, 9);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        check_eq("new_motion_minus3", bus.position, 12);

        // Asynchronous reset mid-line.
        blank(1);
        line(LP, 1'b1, 80, -1);
        blank(2);
        check_eq("pre_async_position", bus.position, 80);
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        #2 reset_n = 1'b0;
        model_clear();
        #1;
        check_eq("async_strobe", bus.strobe, 0);
        check_eq("async_position", bus.position, 0);
        check_eq("async_pixel_x", bus.pixel_x, 0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        reset_n = 1'b1;
        blank(1);
        line(LP, 1'b1, -1, -1);
        check_eq("post_rst_strobe_count", strobe_cnt, 1);
        check_eq("post_rst_strobe_pix", strobe_pix, 1);
        check_eq("post_rst_position", bus.position, 0);

        // Random lines with sparse register writes.
        for (int l = 0; l < 20; l++) begin
            bl = $urandom_range(2, 12);
            vl = $urandom_range(120, 200);
            en = ($urandom_range(0, 3) != 0);
            strobe_cnt = 0;
            for (int i = 0; i < bl + vl; i++) begin
                vis = (i >= bl);
                cycle(vis, en, ($urandom_range(0, 39) == 0), ($urandom_range(0, 29) == 0),
                      ($urandom_range(0, 19) == 0), 4'($urandom_range(0, 15)));
            end
            $display("[tb] random line %0d: blank=%0d visible=%0d en=%0d strobes=%0d pos=%0d",
                     l, bl, vl, en, strobe_cnt, bus.position);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
